// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave serving single NONSEQ transfers from a word-organised SRAM.
// Byte-lane steering, programmable wait states, and ERROR responses for
// misaligned, oversize or out-of-region transfers.
module ahb_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 3;
  localparam logic [32:0] REGION_BYTES = 33'(1) << (ADDR_WIDTH + 2);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   hreadyout_d, hresp_d;

  // Registered data-phase context of the accepted transfer
  logic                   wr_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [3:0]             mask_q;

  logic [31:0]            mem [DEPTH];

  logic                   accept_c, slot_c, start_c, err_c;
  logic [31:0]            offset_c;
  logic [3:0]             mask_c;
  logic [ADDR_WIDTH-1:0]  word_c;
  logic                   we_c, rd_new_c, rd_wait_c, rd_load_c;
  logic [ADDR_WIDTH-1:0]  raddr_c;
  logic [31:0]            rword_c;

  // HTRANS[0] (BUSY vs IDLE, SEQ vs NONSEQ) and HBURST carry no meaning here
  logic unused_c;
  assign unused_c = ^{HTRANS[0], HBURST};

  // Address-phase decode: lane mask, word index and legality
  always_comb begin
    offset_c = HADDR - BASE_ADDR;
    word_c   = HADDR[ADDR_WIDTH+1:2];
    mask_c   = 4'b0000;
    err_c    = 1'b0;
    case (HSIZE)
      3'b000:  mask_c = 4'b0001 << HADDR[1:0];
      3'b001:  mask_c = HADDR[1] ? 4'b1100 : 4'b0011;
      3'b010:  mask_c = 4'b1111;
      default: mask_c = 4'b0000;
    endcase
    if (HSIZE > 3'b010) err_c = 1'b1;
    if ((HSIZE == 3'b001) && HADDR[0]) err_c = 1'b1;
    if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) err_c = 1'b1;
    if ((HADDR < BASE_ADDR) || ({1'b0, offset_c} >= REGION_BYTES)) err_c = 1'b1;
  end

  assign accept_c = HSEL & HREADY & HTRANS[1];
  assign slot_c   = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
  assign start_c  = accept_c & slot_c;

  // Next-state logic and registered-output preview
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_LAST, S_ERR2: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (start_c) begin
          if (err_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_LAST;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_LAST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    hreadyout_d = !((state_d == S_WAIT) || (state_d == S_ERR1));
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  // State, counter and handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      HREADYOUT <= hreadyout_d;
      HRESP     <= hresp_d;
    end
  end

  // Capture transfer context on accept; errored transfers never write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= 1'b0;
      waddr_q <= '0;
      mask_q  <= '0;
    end else if (start_c) begin
      wr_q    <= HWRITE & ~err_c;
      waddr_q <= word_c;
      mask_q  <= mask_c;
    end else if ((state_q == S_LAST) || (state_q == S_ERR2)) begin
      wr_q    <= 1'b0;
    end
  end

  // Write commits on the edge ending LAST; reset drops it
  assign we_c = (state_q == S_LAST) & wr_q & ~rst_i;

  // Read load happens on the edge entering LAST
  assign rd_new_c  = start_c & ~err_c & ~HWRITE & (WAIT_STATES == 0);
  assign rd_wait_c = (state_q == S_WAIT) & (cnt_q <= CNT_W'(1)) & ~wr_q;
  assign rd_load_c = rd_new_c | rd_wait_c;
  assign raddr_c   = rd_new_c ? word_c : waddr_q;

  // Read word with same-cycle forwarding of lanes being written right now
  always_comb begin
    rword_c = mem[raddr_c];
    if (we_c && (waddr_q == raddr_c)) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) rword_c[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Read data register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      HRDATA <= '0;
    end else if (rd_load_c) begin
      HRDATA <= rword_c;
    end
  end

  // SRAM array with per-lane write enable; contents survive reset
  always_ff @(posedge clk_i) begin
    if (we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) mem[waddr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with 0, 3 and 2 wait
// states share one master; a byte-level memory model predicts every response.
module tb_ahb_sram_slave;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NDUT  = 3;

  logic        clk;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [2:0]  hrdyo;
  logic [2:0]  hresp;
  logic [31:0] hrdata [NDUT];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          d;
    bit          drop;
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mref [NDUT][4*DEPTH];
  logic [31:0] last_a = 32'h0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    ahb_sram_slave #(
      .ADDR_WIDTH (10),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .BASE_ADDR  (32'h0000_0000)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HWDATA   (hwdata),
      .HREADY   (hrdyo[g]),
      .HREADYOUT(hrdyo[g]),
      .HRESP    (hresp[g]),
      .HRDATA   (hrdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  // Legal iff size is byte/half/word, naturally aligned and inside the region
  function automatic bit model_err(logic [2:0] sz, logic [31:0] a);
    if (sz > 3'd2) return 1'b1;
    if ((a % (32'd1 << sz)) != 0) return 1'b1;
    return a >= 32'(4 * DEPTH);
  endfunction

  function automatic logic [31:0] model_word(int d, logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mref[d][b+3], mref[d][b+2], mref[d][b+1], mref[d][b]};
  endfunction

  function automatic void model_write(int d, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) begin
      int ba;
      ba = int'(a) + i;
      mref[d][ba] = wd[8*(ba % 4) +: 8];
    end
  endfunction

  // Wait until the selected slave is ready, then let the edge accept
  task automatic wait_ready(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (hrdyo[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: dut%0d got ready=%b expected 1", d, hrdyo[d]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input bit drop);
    exp_t e;
    hsel   = 3'b001 << d;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    hburst = 3'($urandom);
    wait_ready(d);
    hwdata = wd;
    e.d     = d;
    e.drop  = drop;
    e.err   = model_err(sz, a);
    e.rd    = !wr;
    e.rdata = 32'h0;
    e.waits = e.err ? 1 : ws_of(d);
    if (!drop && !e.err) begin
      if (wr) model_write(d, sz, a, wd);
      else    e.rdata = model_word(d, a);
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int d, input int n, input bit sel);
    hsel = sel ? (3'b001 << d) : 3'b000;
    for (int i = 0; i < n; i++) begin
      htrans = sel ? 2'($urandom_range(0, 1)) : 2'b00;
      @(posedge clk);
      #1;
    end
    htrans = 2'b00;
  endtask

  task automatic preload(input int d);
    for (int w = 0; w < 32; w++) issue(d, 1'b1, 3'd2, 32'(w * 4), $urandom, 1'b0);
    idle(d, 1, 1'b0);
  endtask

  task automatic rand_xfer(input int d);
    bit          wr;
    int          r;
    logic [2:0]  sz;
    logic [31:0] a;
    wr = 1'($urandom_range(0, 1));
    r  = $urandom_range(0, 19);
    sz = 3'($urandom_range(0, 2));
    a  = 32'($urandom_range(0, 127));
    if (r == 0) sz = 3'($urandom_range(3, 7));
    if (r != 1 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
    if (r == 2) a = 32'h0000_1000 + a;
    if (r == 3) a = 32'hFFFF_FF00 | a;
    if (r >= 4 && r <= 7) begin
      a  = last_a;
      wr = 1'b0;
      sz = 3'd2;
    end
    if (!model_err(sz, a) && wr) last_a = a & ~32'd3;
    issue(d, wr, sz, a, $urandom, 1'b0);
    if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2), 1'b1);
  endtask

  // Monitor: checks every data phase against the scoreboard head
  bit pend [NDUT];
  int low  [NDUT];
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        if (pend[d] && sb.size() > 0) void'(sb.pop_front());
        pend[d] = 1'b0;
      end else begin
        if (pend[d]) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
            pend[d] = 1'b0;
          end else if (hrdyo[d] === 1'b0) begin
            low[d]++;
            chk("wait_hresp", 32'(hresp[d]), 32'(sb[0].err));
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_dut", 32'(d), 32'(e.d));
            chk("wait_cycles", 32'(low[d]), 32'(e.waits));
            chk("last_hresp", 32'(hresp[d]), 32'(e.err));
            if (e.rd && !e.err) chk("hrdata", hrdata[d], e.rdata);
            pend[d] = 1'b0;
          end
        end else begin
          chk("idle_ready", 32'(hrdyo[d]), 32'd1);
          chk("idle_okay", 32'(hresp[d]), 32'd0);
        end
        if (hsel[d] && hrdyo[d] && htrans[1]) begin
          pend[d] = 1'b1;
          low[d]  = 0;
        end
      end
    end
  end

  initial begin
    int c0;
    int n;
    rst    = 1'b1;
    hsel   = 3'b000;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_ready", 32'(hrdyo[d]), 32'd1);
      chk("reset_hresp", 32'(hresp[d]), 32'd0);
      chk("reset_hrdata", hrdata[d], 32'h0);
    end
    @(posedge clk);
    #1;

    // Zero-wait instance: forwarding, lanes, errors, throughput, random
    preload(0);
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0);
    issue(0, 1'b1, 3'd0, 32'h22, 32'h00AA0000, 1'b0);
    issue(0, 1'b1, 3'd1, 32'h20, 32'h0000BEEF, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);
    idle(0, 1, 1'b0);
    issue(0, 1'b1, 3'd2, 32'h31, 32'h12345678, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd3, 32'h30, 32'h87654321, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
    issue(0, 1'b1, 3'd2, 32'(4 * DEPTH), 32'hA5A5A5A5, 1'b0);
    issue(0, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0);
    idle(0, 2, 1'b1);
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue(0, 1'(i % 2), 3'd2, 32'(i * 4), $urandom, 1'b0);
    chk("b2b_cycles", 32'(cyc - c0), 32'd8);
    for (int i = 0; i < 250; i++) rand_xfer(0);
    idle(0, 2, 1'b0);

    // Three-wait instance
    preload(1);
    issue(1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);
    issue(1, 1'b1, 3'd2, 32'h14, 32'hC0DE0001, 1'b0);
    issue(1, 1'b0, 3'd2, 32'h14, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++) rand_xfer(1);
    idle(1, 5, 1'b0);

    // Two-wait instance with a reset during a write's wait states
    preload(2);
    issue(2, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
    issue(2, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 1'b1);
    hsel   = 3'b000;
    htrans = 2'b00;
    rst    = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(hrdyo[2]), 32'd1);
    chk("midrst_hresp", 32'(hresp[2]), 32'd0);
    chk("midrst_hrdata", hrdata[2], 32'h0);
    @(posedge clk);
    #1;
    issue(2, 1'b0, 3'd2, 32'h40, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++) rand_xfer(2);

    idle(2, 2, 1'b0);
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that sits at the far end of the Ibex-to-AHB bridge and serves single NONSEQ transfers from a word-organised on-chip SRAM.
- Supports byte, halfword and word transfers with byte-lane steering, and a configurable number of wait states.
- Returns an ERROR response for illegal transfers and for addresses beyond the array.
- Instantiated once per memory region behind the SoC address decoder, which drives HSEL.

Parameters:
- ADDR_WIDTH, 10: word-address bits; array depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0: wait cycles per transfer, range 0..7. HREADYOUT is held low for this many cycles in each data phase.
- BASE_ADDR, 32'h0000_0000: byte base of the region. Only offsets below 4*2**ADDR_WIDTH are valid.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address, sampled in the address phase.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; all other values are illegal.
- HBURST  in  3  ignored; every transfer is treated as a single transfer.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready; a new address phase is accepted only when this is high.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data; full word, unaligned lanes carry array contents.

Behaviour:
- Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, pending-write register cleared. The array is not cleared.
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, register HWRITE, HSIZE, word address HADDR[ADDR_WIDTH+1:2] and lane mask.
- IDLE/BUSY with HSEL=1, or HSEL=0: no transfer occurs. The next data phase is zero-wait OKAY.
- Lane mask:
  - byte: 1 << HADDR[1:0].
  - halfword: 0011 when HADDR[1]=0, 1100 when HADDR[1]=1.
  - word: 1111.
- Error conditions, checked on accept:
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0] != 0;
  - HADDR - BASE_ADDR >= 4*2**ADDR_WIDTH, or HADDR < BASE_ADDR.
- States:
  - IDLE: no data phase pending.
  - WAIT: counter runs from WAIT_STATES down to 1, with HREADYOUT=0 and HRESP=0.
  - LAST: HREADYOUT=1 and HRESP=0; the transfer completes this cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - On a legal accept: go to WAIT if WAIT_STATES>0, otherwise to LAST.
  - On an illegal accept: go to ERR1, then ERR2. Wait states are not inserted for errors.
  - From LAST or ERR2: go to WAIT/LAST/ERR1 if a new accept occurs in the same cycle (pipelined), otherwise to IDLE.
  - Accepts are impossible in WAIT and ERR1 because HREADY is low.
- Write timing: the array is updated on the edge that ends LAST, masked by the lane mask. HWDATA is sampled in that cycle.
- Errored transfers write nothing and leave HRDATA unchanged.
- Read timing: HRDATA is loaded from the array on the edge entering LAST and is held stable through LAST. Outside LAST after a read, HRDATA holds its last value.
- Read-after-write hazard: a read accepted in the LAST cycle of a write to the same word must return the merged data. Written lanes come from HWDATA; the other lanes come from the array. Same-cycle forwarding is required, with no extra wait state.
- Back-to-back transfers: with WAIT_STATES=0, sustain one transfer per cycle.
- Reset mid-transfer: any pending write is dropped, outputs return to reset values on the next edge, and the array holds its prior contents.

Test Plan:
- Reset then idle: assert rst_i for 2 cycles with HTRANS=00 -> HREADYOUT=1, HRESP=0, HRDATA=0.
- Word write then read, WAIT_STATES=0:
  - Stimulus: NONSEQ write 0x0000_0010 with HWDATA=DEADBEEF, then NONSEQ read 0x10 in the next cycle.
  - Response: the read returns DEADBEEF in the cycle after its address phase, via forwarding.
- Byte and halfword lanes:
  - Stimulus: word-write 0x20=11223344, then byte-write 0x22 with HWDATA=00AA0000, then halfword-write 0x20 with HWDATA=0000BEEF.
  - Response: a word read of 0x20 returns 11AABEEF.
- Wait states, WAIT_STATES=3: a read of 0x10 gives HREADYOUT low for exactly 3 cycles, then high for 1 cycle with HRDATA valid. The bus holds HADDR for the next transfer until HREADY is high.
- Errors, each followed by a read of 0x30 that must return its prior contents unchanged:
  - word write to 0x31;
  - HSIZE=011;
  - address 4*2**ADDR_WIDTH.
  - Each -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1), with no array change.
- Reset mid-write, WAIT_STATES=2: assert rst_i during WAIT of a write of 0x40=CAFEF00D -> a later read of 0x40 returns its old value, and outputs are at reset values one cycle after rst_i.
